// File: rtl/echo_ind_pkg.sv
// Shared definitions for the EchoIndication method-to-pipe serializer:
// message layout, method tags and the per-method message encoders.
package echo_ind_pkg;

  localparam int unsigned TAG_W  = 16;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MSG_W  = TAG_W + DATA_W;
  localparam int unsigned N_METH = 3;

  localparam logic [TAG_W-1:0] TAG_HEARD  = 16'd0;
  localparam logic [TAG_W-1:0] TAG_HEARD2 = 16'd1;
  localparam logic [TAG_W-1:0] TAG_HEARD3 = 16'd2;

  localparam int unsigned TAG_MSB      = 143;
  localparam int unsigned TAG_LSB      = 128;
  localparam int unsigned HEARD_V_MSB  = 111;
  localparam int unsigned HEARD_V_LSB  = 80;
  localparam int unsigned HEARD2_A_MSB = 111;
  localparam int unsigned HEARD2_A_LSB = 96;
  localparam int unsigned HEARD2_B_MSB = 95;
  localparam int unsigned HEARD2_B_LSB = 80;
  localparam int unsigned HEARD3_V_MSB = 87;
  localparam int unsigned HEARD3_V_LSB = 80;

  typedef logic [MSG_W-1:0] msg_t;

  typedef enum logic [1:0] {
    M_HEARD  = 2'd0,
    M_HEARD2 = 2'd1,
    M_HEARD3 = 2'd2
  } meth_e;

  function automatic msg_t enc_heard(input logic [31:0] v);
    msg_t m;
    m = '0;
    m[TAG_MSB:TAG_LSB]         = TAG_HEARD;
    m[HEARD_V_MSB:HEARD_V_LSB] = v;
    return m;
  endfunction

  function automatic msg_t enc_heard2(input logic [15:0] a, input logic [15:0] b);
    msg_t m;
    m = '0;
    m[TAG_MSB:TAG_LSB]           = TAG_HEARD2;
    m[HEARD2_A_MSB:HEARD2_A_LSB] = a;
    m[HEARD2_B_MSB:HEARD2_B_LSB] = b;
    return m;
  endfunction

  function automatic msg_t enc_heard3(input logic [7:0] v);
    msg_t m;
    m = '0;
    m[TAG_MSB:TAG_LSB]           = TAG_HEARD3;
    m[HEARD3_V_MSB:HEARD3_V_LSB] = v;
    return m;
  endfunction

  // Round-robin pick: first requester at or after ptr, in heard->heard2->heard3 order.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input meth_e ptr);
    logic [2:0] rot;
    logic [2:0] p;
    logic [2:0] g;
    case (ptr)
      M_HEARD2: rot = {req[0], req[2:1]};
      M_HEARD3: rot = {req[1:0], req[2]};
      default:  rot = req;
    endcase
    if (rot[0])      p = 3'b001;
    else if (rot[1]) p = 3'b010;
    else if (rot[2]) p = 3'b100;
    else             p = 3'b000;
    case (ptr)
      M_HEARD2: g = {p[1:0], p[2]};
      M_HEARD3: g = {p[0], p[2:1]};
      default:  g = p;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/m2p_echo_indication_if.sv
// EchoIndication method calls plus the PipeIn enq channel they are serialized onto.
interface m2p_echo_indication_if;
  import echo_ind_pkg::*;

  logic        heard__ENA;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        heard2__ENA;
  logic [15:0] heard2_a;
  logic [15:0] heard2_b;
  logic        heard2__RDY;
  logic        heard3__ENA;
  logic [7:0]  heard3_v;
  logic        heard3__RDY;
  logic        enq__ENA;
  msg_t        enq_v;
  logic        enq__RDY;

  modport master (
    output heard__ENA, heard_v, heard2__ENA, heard2_a, heard2_b, heard3__ENA, heard3_v,
    input  heard__RDY, heard2__RDY, heard3__RDY,
    input  enq__ENA, enq_v,
    output enq__RDY
  );

  modport slave (
    input  heard__ENA, heard_v, heard2__ENA, heard2_a, heard2_b, heard3__ENA, heard3_v,
    output heard__RDY, heard2__RDY, heard3__RDY,
    output enq__ENA, enq_v,
    input  enq__RDY
  );

endinterface

// File: rtl/m2p_msg_fifo.sv
// Synchronous FIFO for encoded messages; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module m2p_msg_fifo #(
  parameter int unsigned WIDTH = 144,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/m2p_echo_indication.sv
// EchoIndication method-to-pipe serializer: per-method hold registers, a
// round-robin arbiter and an encoder feeding a message FIFO onto pipe.enq.
module m2p_echo_indication
  import echo_ind_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  CLK,
  input logic                  nRST,
  m2p_echo_indication_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]  hold_valid_q, hold_valid_d;
  logic [31:0] heard_v_q, heard_v_d;
  logic [15:0] heard2_a_q, heard2_a_d;
  logic [15:0] heard2_b_q, heard2_b_d;
  logic [7:0]  heard3_v_q, heard3_v_d;
  meth_e       rr_q, rr_d;

  logic [2:0]       call_c, grant_c;
  logic             pop_c, space_c;
  msg_t             msg_c;
  msg_t             fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // A call is only taken while its hold register is free; otherwise ignored.
  assign call_c = {bus.heard3__ENA, bus.heard2__ENA, bus.heard__ENA} & ~hold_valid_q;

  assign bus.heard__RDY  = !hold_valid_q[0];
  assign bus.heard2__RDY = !hold_valid_q[1];
  assign bus.heard3__RDY = !hold_valid_q[2];

  assign bus.enq__ENA = !fifo_empty;
  assign bus.enq_v    = fifo_head;
  assign pop_c        = !fifo_empty && bus.enq__RDY;

  assign space_c = (fifo_count < CNT_W'(FIFO_DEPTH)) || (fifo_full && pop_c);
  assign grant_c = space_c ? rr_pick(hold_valid_q, rr_q) : 3'b000;

  always_comb begin
    hold_valid_d = hold_valid_q & ~grant_c;
    heard_v_d    = heard_v_q;
    heard2_a_d   = heard2_a_q;
    heard2_b_d   = heard2_b_q;
    heard3_v_d   = heard3_v_q;
    if (call_c[0]) begin
      hold_valid_d[0] = 1'b1;
      heard_v_d       = bus.heard_v;
    end
    if (call_c[1]) begin
      hold_valid_d[1] = 1'b1;
      heard2_a_d      = bus.heard2_a;
      heard2_b_d      = bus.heard2_b;
    end
    if (call_c[2]) begin
      hold_valid_d[2] = 1'b1;
      heard3_v_d      = bus.heard3_v;
    end
  end

  // Encode the winner and move the pointer just past it.
  always_comb begin
    msg_c = enc_heard3(heard3_v_q);
    rr_d  = rr_q;
    if (grant_c[0]) begin
      msg_c = enc_heard(heard_v_q);
      rr_d  = M_HEARD2;
    end else if (grant_c[1]) begin
      msg_c = enc_heard2(heard2_a_q, heard2_b_q);
      rr_d  = M_HEARD3;
    end else if (grant_c[2]) begin
      rr_d  = M_HEARD;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      hold_valid_q <= '0;
      heard_v_q    <= '0;
      heard2_a_q   <= '0;
      heard2_b_q   <= '0;
      heard3_v_q   <= '0;
      rr_q         <= M_HEARD;
    end else begin
      hold_valid_q <= hold_valid_d;
      heard_v_q    <= heard_v_d;
      heard2_a_q   <= heard2_a_d;
      heard2_b_q   <= heard2_b_d;
      heard3_v_q   <= heard3_v_d;
      rr_q         <= rr_d;
    end
  end

  m2p_msg_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (nRST),
    .push_i  (|grant_c),
    .data_i  (msg_c),
    .pop_i   (pop_c),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
